fmul_issue_queue: RTL and testbench

Flow-control wrapper that sits directly upstream and downstream of the pipelined single-precision multiplier `FMul`. `FMul` has a fixed latency, no valid signal and cannot stall. This block accepts operand pairs over a valid/ready handshake and launches them into `FMul`. It tracks in-flight products with a valid shift register and captures results into a credit-protected result FIFO, which is drained over a second valid/ready handshake. Because of the credit rule, no product is ever dropped, whatever the consumer's backpressure.

---
 rtl/fmul_issue_queue.sv | 107 ++++++++++
 tb/tb_fmul_issue_queue.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_issue_queue.sv
// fmul_issue_queue: valid/ready wrapper around the fixed-latency, non-stalling
// FMul pipeline. Operands launch only when a result slot is guaranteed, so
// products leaving FMul are always captured into the result FIFO.
module fmul_issue_queue #(
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  input  logic          in_last,
  output logic [31:0]   mul_in1,
  output logic [31:0]   mul_in2,
  input  logic [31:0]   mul_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic [CW-1:0] occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [LAT-1:0] vsr_q, vsr_d;
  logic [LAT-1:0] lsr_q, lsr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [32:0]    mem_q [DEPTH];
  logic           issue;
  logic           push;
  logic           pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit: every in-flight product already owns a FIFO slot. in_ready is
  // built from registered state only, so out_ready never reaches it.
  assign occupancy = count_q + CW'($countones(vsr_q));
  assign in_ready  = ~rst & (occupancy < CW'(DEPTH));
  assign issue     = in_valid & in_ready;

  // Idle cycles present zeros to FMul rather than stale operands.
  assign mul_in1 = issue ? in_a : '0;
  assign mul_in2 = issue ? in_b : '0;

  assign push      = vsr_q[LAT-1];
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;

  // Head is masked when empty so the outputs read zero after reset.
  assign out_data = out_valid ? mem_q[rd_ptr_q][31:0] : '0;
  assign out_last = out_valid & mem_q[rd_ptr_q][32];

  // Next-state: shift the in-flight tags, advance pointers and count.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    vsr_d    = vsr_q << 1;
    lsr_d    = lsr_q << 1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    vsr_d[0] = issue;
    lsr_d[0] = in_last;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    if (rst) begin
      vsr_q    <= '0;
      lsr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      vsr_q    <= vsr_d;
      lsr_q    <= lsr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Result storage: capture {last, product} when the tagged slot exits FMul.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; validity is carried entirely by count_q.
    if (push) mem_q[wr_ptr_q] <= {lsr_q[LAT-1], mul_out};
  end

endmodule

// File: tb/tb_fmul_issue_queue.sv
// Bench for fmul_issue_queue: two instances (DEPTH 8 and DEPTH 5) share the
// stimulus; each is compared every cycle against a queue-level model, and
// directed phases pin literal timings and values.
module tb_fmul_issue_queue;

  localparam int LAT = 4;

  typedef struct packed { logic [31:0] d; logic l; } ent_t;
  typedef struct packed { logic [31:0] d; logic l; logic [7:0] age; } inf_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last, out_ready;
  logic [31:0] in_a, in_b;

  logic        in_ready_w  [2];
  logic [31:0] mul_in1_w   [2];
  logic [31:0] mul_in2_w   [2];
  logic [31:0] mul_out_w   [2];
  logic        out_valid_w [2];
  logic [31:0] out_data_w  [2];
  logic        out_last_w  [2];
  logic [3:0]  occ0;
  logic [2:0]  occ1;
  logic [31:0] pipe0 [LAT];
  logic [31:0] pipe1 [LAT];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic run = 1'b0;
  int   delivered [2];
  inf_t infl [2][$];
  ent_t fq   [2][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fmul_issue_queue #(.LAT(LAT), .DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_in1(mul_in1_w[0]), .mul_in2(mul_in2_w[0]), .mul_out(mul_out_w[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_data(out_data_w[0]),
    .out_last(out_last_w[0]), .occupancy(occ0)
  );

  fmul_issue_queue #(.LAT(LAT), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mul_in1(mul_in1_w[1]), .mul_in2(mul_in2_w[1]), .mul_out(mul_out_w[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_data(out_data_w[1]),
    .out_last(out_last_w[1]), .occupancy(occ1)
  );

  // Single-precision multiply, round-to-nearest-even, normal operands only.
  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic        s, rb, st, c;
    int          e;
    logic [47:0] p;
    logic [23:0] m;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      m = p[47:24]; rb = p[23]; st = |p[22:0];
    end else begin
      m = p[46:23]; rb = p[22]; st = |p[21:0];
    end
    if (rb && (st || m[0])) begin
      {c, m} = {1'b0, m} + 25'd1;
      if (c) begin m = 24'h800000; e++; end
    end
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_norm();
    logic s; logic [7:0] e; logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    e = 8'($urandom_range(100, 150));
    m = 23'($urandom);
    return {s, e, m};
  endfunction

  function automatic int depth_of(input int i);
    return (i == 0) ? 8 : 5;
  endfunction

  // Stand-in FMul: fixed LAT-stage pipeline, no valid, never stalls.
  always @(posedge clk) begin
    pipe0[0] <= fmul_ref(mul_in1_w[0], mul_in2_w[0]);
    pipe1[0] <= fmul_ref(mul_in1_w[1], mul_in2_w[1]);
    for (int k = 1; k < LAT; k++) begin
      pipe0[k] <= pipe0[k-1];
      pipe1[k] <= pipe1[k-1];
    end
  end
  assign mul_out_w[0] = pipe0[LAT-1];
  assign mul_out_w[1] = pipe1[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Compare one instance against the model, then advance the model over the coming edge.
  task automatic step(input int i, input logic rdy, input logic ov, input logic [31:0] od,
                      input logic ol, input int occ, input logic [31:0] m1, input logic [31:0] m2);
    int   eocc;
    logic erdy, eiss, eov, full;
    ent_t h, e;
    inf_t t;
    eocc = infl[i].size() + fq[i].size();
    erdy = !rst && (eocc < depth_of(i));
    eiss = in_valid && erdy;
    eov  = (fq[i].size() != 0);
    h    = eov ? fq[i][0] : '0;
    check($sformatf("u%0d in_ready", i),  32'(rdy), 32'(erdy));
    check($sformatf("u%0d occupancy", i), 32'(occ), 32'(eocc));
    check($sformatf("u%0d out_valid", i), 32'(ov),  32'(eov));
    check($sformatf("u%0d out_data", i),  od,       h.d);
    check($sformatf("u%0d out_last", i),  32'(ol),  32'(h.l));
    check($sformatf("u%0d mul_in1", i),   m1,       eiss ? in_a : 32'd0);
    check($sformatf("u%0d mul_in2", i),   m2,       eiss ? in_b : 32'd0);
    if (rst) begin
      infl[i].delete();
      fq[i].delete();
    end else begin
      full = (fq[i].size() >= depth_of(i));
      if (eov && out_ready) begin
        void'(fq[i].pop_front());
        delivered[i]++;
      end
      if (infl[i].size() != 0) begin
        t = infl[i][0];
        if (t.age == 8'(LAT - 1)) begin
          check($sformatf("u%0d no push into full fifo", i), 32'(full), 32'd0);
          void'(infl[i].pop_front());
          e.d = t.d; e.l = t.l;
          fq[i].push_back(e);
        end
      end
      for (int k = 0; k < infl[i].size(); k++) begin
        t = infl[i][k]; t.age = t.age + 8'd1; infl[i][k] = t;
      end
      if (eiss) begin
        t.d = fmul_ref(in_a, in_b); t.l = in_last; t.age = 8'd0;
        infl[i].push_back(t);
      end
    end
  endtask

  // Per-cycle comparison on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      step(0, in_ready_w[0], out_valid_w[0], out_data_w[0], out_last_w[0], int'(occ0),
           mul_in1_w[0], mul_in2_w[0]);
      step(1, in_ready_w[1], out_valid_w[1], out_data_w[1], out_last_w[1], int'(occ1),
           mul_in1_w[1], mul_in2_w[1]);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bp_b [10] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
  logic [31:0] bp_p [8]  = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
                             32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};
  logic [31:0] sa [100];
  logic [31:0] sb [100];

  initial begin
    int k, acc, n, ncyc, d0;
    logic [31:0] wa, wb;
    delivered[0] = 0; delivered[1] = 0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    next_cycle();
    run = 1'b1;
    next_cycle();
    #2;
    check("reset out_valid", 32'(out_valid_w[0]), 32'd0);
    check("reset out_data",  out_data_w[0],       32'd0);
    check("reset occupancy", 32'(occ0),           32'd0);
    check("reset in_ready",  32'(in_ready_w[0]),  32'd0);

    // Single product, 1.5 * 2.0, issued in cycle 0.
    next_cycle(); rst = 1'b0; out_ready = 1'b1;
    next_cycle();
    in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000; in_last = 1'b1;
    #2 check("single in_ready", 32'(in_ready_w[0]), 32'd1);
    next_cycle(); in_valid = 1'b0; in_last = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #2;
      check($sformatf("single occupancy c%0d", c), 32'(occ0), (c <= 5) ? 32'd1 : 32'd0);
      check($sformatf("single out_valid c%0d", c), 32'(out_valid_w[0]), (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) begin
        check("single out_data", out_data_w[0],       32'h40400000);
        check("single out_last", 32'(out_last_w[0]),  32'd1);
      end
      next_cycle();
    end

    // Backpressure: 10 pairs offered with out_ready low, 8 fit.
    out_ready = 1'b0; k = 0; acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (k < 10);
      in_a = 32'h40000000;
      in_b = (k < 10) ? bp_b[k] : 32'd0;
      #2;
      if (in_valid && in_ready_w[0]) begin acc++; k++; end
      next_cycle();
    end
    in_valid = 1'b0;
    #2;
    check("bp accepted",  32'(acc),            32'd8);
    check("bp in_ready",  32'(in_ready_w[0]),  32'd0);
    check("bp occupancy", 32'(occ0),           32'd8);
    next_cycle(); out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      #2;
      check($sformatf("bp drain valid %0d", j), 32'(out_valid_w[0]), 32'd1);
      check($sformatf("bp drain data %0d", j),  out_data_w[0],        bp_p[j]);
      if (j < 2) check($sformatf("bp in_ready after pop %0d", j), 32'(in_ready_w[0]), 32'(j));
      next_cycle();
    end
    for (int c = 0; c < 10; c++) next_cycle();

    // Streaming: 100 random normal pairs back to back.
    for (int i = 0; i < 100; i++) begin sa[i] = rnd_norm(); sb[i] = rnd_norm(); end
    d0 = delivered[0]; n = 0; ncyc = 0;
    while (n < 100 && ncyc < 200) begin
      in_valid = 1'b1; in_a = sa[n]; in_b = sb[n]; in_last = (n == 99);
      #2;
      if (in_ready_w[0]) n++;
      ncyc++;
      next_cycle();
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("stream cycles for 100 issues", 32'(ncyc), 32'd100);
    for (int c = 0; c < 10; c++) next_cycle();
    check("stream outputs delivered", 32'(delivered[0] - d0), 32'd100);

    // Random valid and ready.
    for (int c = 0; c < 300; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_last   = 1'($urandom_range(0, 1));
      in_a = rnd_norm(); in_b = rnd_norm();
      next_cycle();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) next_cycle();

    // Reset with 3 products in the FIFO and 4 in flight.
    out_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      in_valid = (c < 3) || (c >= 7);
      in_a = rnd_norm(); in_b = rnd_norm();
      if (in_valid) begin
        #2 check($sformatf("rst-test issue %0d", c), 32'(in_ready_w[0]), 32'd1);
      end
      next_cycle();
    end
    rst = 1'b1; in_valid = 1'b1; in_a = 32'h3FC00000; in_b = 32'h40000000;
    #2;
    check("pre-reset occupancy", 32'(occ0),           32'd7);
    check("in_ready during rst", 32'(in_ready_w[0]),  32'd0);
    check("mul_in1 during rst",  mul_in1_w[0],        32'd0);
    next_cycle(); rst = 1'b0; out_ready = 1'b1;
    #2;
    check("post-reset out_valid", 32'(out_valid_w[0]), 32'd0);
    check("post-reset occupancy", 32'(occ0),           32'd0);
    check("post-reset in_ready",  32'(in_ready_w[0]),  32'd1);
    next_cycle(); in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #2;
      check($sformatf("post-reset out_valid c%0d", c), 32'(out_valid_w[0]), (c == 5) ? 32'd1 : 32'd0);
      if (c == 5) check("post-reset product", out_data_w[0], 32'h40400000);
      next_cycle();
    end

    // Wrap-around on the DEPTH=5 instance: 23 products, intermittent ready.
    for (int c = 0; c < 10; c++) next_cycle();
    d0 = delivered[1]; n = 0; ncyc = 0;
    wa = rnd_norm(); wb = rnd_norm();
    while (n < 23 && ncyc < 400) begin
      in_valid = 1'b1; in_a = wa; in_b = wb; in_last = (n == 22);
      out_ready = ($urandom_range(0, 2) == 0);
      #2;
      if (in_ready_w[1]) begin n++; wa = rnd_norm(); wb = rnd_norm(); end
      ncyc++;
      next_cycle();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    check("wrap issued", 32'(n), 32'd23);
    for (int c = 0; c < 20; c++) next_cycle();
    check("wrap delivered", 32'(delivered[1] - d0), 32'd23);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
